// File: rtl/uart_rx_fifo_if.sv
// Byte-stream handshake between a UART receiver, the RX FIFO and its consumer.
// The master modport belongs to the producer/consumer side. The slave modport belongs to the FIFO.
interface uart_rx_fifo_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [7:0]    din;
    logic          rd_en;
    logic          clr_ovf;
    logic [7:0]    dout;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;

    modport master (
        output wr_en, din, rd_en, clr_ovf,
        input  dout, empty, full, count, overflow
    );

    modport slave (
        input  wr_en, din, rd_en, clr_ovf,
        output dout, empty, full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO for a UART receiver, with a sticky overflow flag.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input logic           clk,
    input logic           nrst,
    uart_rx_fifo_if.slave bus
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    if (DEPTH < 2 || DEPTH > 256 || DEPTH != (1 << AW)) begin : g_param_check
        $error("uart_rx_fifo: DEPTH must equal 2**AW and lie in 2..256");
    end

    // Flags come from the registered count, so there is no path from wr_en/rd_en to them.
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign pop   = bus.rd_en & ~empty;
    assign push  = bus.wr_en & (~full | pop);
    assign drop  = bus.wr_en & full & ~pop;

    // NOTE: the storage array is deliberately left without a reset. It stays plain
    // enabled flops (or RAM). The reset-cleared count already marks its contents invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // NOTE: use non-blocking assignments in clocked blocks. Every update then reads
    // the values from before the edge, whatever order the statements appear in.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AW+1)'(1);
            end
            // A new drop takes priority over a clear in the same cycle.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.dout     = mem[rd_ptr];
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule
